masked_sbox_sequencer: RTL

MASKED_SBOX_SEQUENCER -- requirements
Module: masked_sbox_sequencer

---
 rtl/masked_sbox_sequencer_pkg.sv | 50 +++++
 rtl/Masked_SubBytes.sv | 37 +++
 rtl/masked_sbox_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/masked_sbox_sequencer_pkg.sv
// Shared types, sizing constants and GF(2^8) helpers for the masked S-box sequencer.
// Contents: state_t (IDLE/RUN/DONE), NBYTES, RND_W, IDX_W, gf_mul/gf_inv/aes_sbox.
// No logic of its own; pure declarations and combinational functions.
package masked_sbox_sequencer_pkg;

   localparam int NBYTES = 16;
   localparam int RND_W  = 20;
   localparam int IDX_W  = $clog2(NBYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Inverse as x^254 (square-and-multiply); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward AES S-box: field inverse followed by the affine map.
   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/Masked_SubBytes.sv
// Combinational masked S-box: four input shares in, three freshly masked output shares out.
// Ports: i_s1..i_s4 (byte shares), i_rnd (fresh randomness), o_s1..o_s3 (output shares).
// Zero latency, no handshake; the caller decides when the result is captured.
module Masked_SubBytes #(
   parameter int RND_W = masked_sbox_sequencer_pkg::RND_W
) (
   input  logic [7:0]       i_s1,
   input  logic [7:0]       i_s2,
   input  logic [7:0]       i_s3,
   input  logic [7:0]       i_s4,
   input  logic [RND_W-1:0] i_rnd,
   output logic [7:0]       o_s1,
   output logic [7:0]       o_s2,
   output logic [7:0]       o_s3
);
   import masked_sbox_sequencer_pkg::*;

   logic [7:0] w_m1;
   logic [7:0] w_m2;
   logic [7:0] w_y;

   // Low byte is mask 1; every remaining random bit is folded into mask 2
   // so that all of the word contributes to the output sharing.
   always_comb begin
      w_m1 = i_rnd[7:0];
      w_m2 = i_rnd[15:8];
      for (int k = 16; k < RND_W; k++) begin
         w_m2[k[2:0]] = w_m2[k[2:0]] ^ i_rnd[k];
      end
   end

   assign w_y  = aes_sbox(i_s1 ^ i_s2 ^ i_s3 ^ i_s4);
   assign o_s1 = (w_y ^ w_m1) ^ w_m2;
   assign o_s2 = w_m1;
   assign o_s3 = w_m2;

endmodule

// File: rtl/masked_sbox_sequencer.sv
// Runs one masked S-box over NBYTES bytes of a captured four-share state, one byte per random word.
// Ports: clk/rst, start, data_i_1..4 in, rnd_data/rnd_valid/rnd_ready PRNG handshake, busy/done, data_o_1..3.
// Latency NBYTES+1 cycles from start with rnd_valid held high; each rnd_valid=0 cycle in RUN stalls by one.
module masked_sbox_sequencer #(
   parameter int NBYTES = masked_sbox_sequencer_pkg::NBYTES,
   parameter int RND_W  = masked_sbox_sequencer_pkg::RND_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NBYTES*8-1:0]   data_i_1,
   input  logic [NBYTES*8-1:0]   data_i_2,
   input  logic [NBYTES*8-1:0]   data_i_3,
   input  logic [NBYTES*8-1:0]   data_i_4,
   input  logic [RND_W-1:0]      rnd_data,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   output logic                  busy,
   output logic                  done,
   output logic [NBYTES*8-1:0]   data_o_1,
   output logic [NBYTES*8-1:0]   data_o_2,
   output logic [NBYTES*8-1:0]   data_o_3
);
   import masked_sbox_sequencer_pkg::*;

   localparam int IDX_BITS = $clog2(NBYTES);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_BITS-1:0]   r_idx;
   logic [NBYTES*8-1:0]   r_sh1, r_sh2, r_sh3, r_sh4;
   logic [NBYTES*8-1:0]   r_out1, r_out2, r_out3;
   logic                  w_accept;
   logic                  w_hs;
   logic                  w_last;
   logic [7:0]            w_o1, w_o2, w_o3;

   assign w_accept = (r_state == IDLE) && start;
   assign w_hs     = rnd_valid && rnd_ready;
   assign w_last   = (r_idx == IDX_BITS'(NBYTES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (w_hs && w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs; rnd_ready is masked by rst so a word offered during reset is not taken.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      rnd_ready = 1'b0;
      case (r_state)
         RUN: begin
            busy      = 1'b1;
            rnd_ready = !rst;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // One shared S-box, byte lanes selected by the running index.
   Masked_SubBytes #(
      .RND_W (RND_W)
   ) u_sbox (
      .i_s1  (r_sh1[{r_idx, 3'b000} +: 8]),
      .i_s2  (r_sh2[{r_idx, 3'b000} +: 8]),
      .i_s3  (r_sh3[{r_idx, 3'b000} +: 8]),
      .i_s4  (r_sh4[{r_idx, 3'b000} +: 8]),
      .i_rnd (rnd_data),
      .o_s1  (w_o1),
      .o_s2  (w_o2),
      .o_s3  (w_o3)
   );

   // Shares are only loaded on start and never cleared between bytes,
   // so the S-box inputs only toggle when the index moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_sh1  <= '0;
         r_sh2  <= '0;
         r_sh3  <= '0;
         r_sh4  <= '0;
         r_out1 <= '0;
         r_out2 <= '0;
         r_out3 <= '0;
      end else if (w_accept) begin
         r_idx <= '0;
         r_sh1 <= data_i_1;
         r_sh2 <= data_i_2;
         r_sh3 <= data_i_3;
         r_sh4 <= data_i_4;
      end else if (w_hs) begin
         r_out1[{r_idx, 3'b000} +: 8] <= w_o1;
         r_out2[{r_idx, 3'b000} +: 8] <= w_o2;
         r_out3[{r_idx, 3'b000} +: 8] <= w_o3;
         r_idx <= r_idx + IDX_BITS'(1);
      end
   end

   assign data_o_1 = r_out1;
   assign data_o_2 = r_out2;
   assign data_o_3 = r_out3;

endmodule
